// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator core: FSM states, opcodes, error codes and status values.
// The MUL opcode is only legal when the RPN_MUL_EN macro is defined (decided in rpn_alu).
package rpn_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_MUL = 3'd6,
    OP_RSV = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2,
    ERR_OPC  = 2'd3
  } err_t;

  localparam logic [2:0] STATUS_IDLE = 3'd0;
  localparam logic [2:0] STATUS_PUSH = 3'd1;
  localparam logic [2:0] STATUS_EXEC = 3'd2;
  localparam logic [2:0] STATUS_WB   = 3'd3;
  localparam logic [2:0] STATUS_ERR  = 3'd4;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN core: result, carry and opcode legality.
// Opcode 6 (MUL) exists only when RPN_MUL_EN is defined; otherwise it reports illegal.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             legal_o
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH:0] sum;
  assign sum = {1'b0, a_i} + {1'b0, b_i};

`ifdef RPN_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
`endif

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    legal_o = 1'b1;
    case (op_t'(op_i))
      OP_ADD: begin
        res_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_SUB: begin
        res_o   = a_i - b_i;
        carry_o = (a_i < b_i);
      end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_SHL: res_o = a_i << b_i[SW-1:0];
`ifdef RPN_MUL_EN
      OP_MUL: begin
        res_o   = prod[WIDTH-1:0];
        carry_o = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN calculator core: Enter-driven FSM, operand latch, stack register array and occupancy counter.
// Optional multiplier is enabled by defining RPN_MUL_EN (see rpn_alu).
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       Reset_n,
  input  logic                       Clear,
  input  logic                       Enter_pulse,
  input  logic                       IsOp,
  input  logic [WIDTH-1:0]           DataIn,
  input  logic [2:0]                 OpIn,
  output logic [WIDTH-1:0]           Top,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic [2:0]                 Status,
  output logic                       Busy,
  output logic                       Error,
  output logic [1:0]                 ErrCode,
  output logic                       Carry
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  state_t           state_q, state_d;
  err_t             err_q, err_d;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             rcarry_q;
  logic             latch_en;

  logic [IW-1:0]    idx_top, idx_nos, idx_push;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_legal;

  assign idx_top  = IW'(count_q - CW'(1));
  assign idx_nos  = IW'(count_q - CW'(2));
  assign idx_push = IW'(count_q);

  // Legality is judged on the live opcode in IDLE; EXEC computes with the latched one.
  assign alu_op = (state_q == S_EXEC) ? op_q : OpIn;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i     (stack_q[idx_nos]),
    .b_i     (stack_q[idx_top]),
    .op_i    (alu_op),
    .res_o   (alu_res),
    .carry_o (alu_carry),
    .legal_o (alu_legal)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Enter_pulse) begin
          latch_en = 1'b1;
          if (!IsOp) begin
            if (count_q == CW'(DEPTH)) begin
              state_d = S_ERR;
              err_d   = ERR_OVF;
            end else begin
              state_d = S_PUSH;
            end
          end else if (count_q < CW'(2)) begin
            state_d = S_ERR;
            err_d   = ERR_UNF;
          end else if (!alu_legal) begin
            state_d = S_ERR;
            err_d   = ERR_OPC;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_PUSH: state_d = S_IDLE;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      S_ERR: begin
        if (Enter_pulse) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (Clear) begin
      state_d  = S_IDLE;
      err_d    = ERR_NONE;
      latch_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      count_q <= '0;
      carry_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (Clear) begin
        count_q <= '0;
        carry_q <= 1'b0;
      end else if (state_q == S_PUSH) begin
        stack_q[idx_push] <= data_q;
        count_q           <= count_q + CW'(1);
      end else if (state_q == S_WB) begin
        stack_q[idx_nos] <= res_q;
        count_q          <= count_q - CW'(1);
        carry_q          <= rcarry_q;
      end
    end
  end

  // Operand latch and EXEC result register carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      data_q <= DataIn;
      op_q   <= OpIn;
    end
    if (state_q == S_EXEC) begin
      res_q    <= alu_res;
      rcarry_q <= alu_carry;
    end
  end

  assign Top     = (count_q == '0) ? '0 : stack_q[idx_top];
  assign Count   = count_q;
  assign Status  = state_q;
  assign Busy    = (state_q == S_PUSH) || (state_q == S_EXEC) || (state_q == S_WB);
  assign Error   = (state_q == S_ERR);
  assign ErrCode = err_q;
  assign Carry   = carry_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc (WIDTH=16, DEPTH=4) with hand-computed expectations.
module tb_rpn_stack_calc;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Clear = 1'b0;
  logic        Enter_pulse = 1'b0;
  logic        IsOp = 1'b0;
  logic [15:0] DataIn = '0;
  logic [2:0]  OpIn = '0;
  logic [15:0] Top;
  logic [2:0]  Count;
  logic [2:0]  Status;
  logic        Busy, Error, Carry;
  logic [1:0]  ErrCode;

  int n_tests = 0;
  int n_fail  = 0;

  rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .Clear       (Clear),
    .Enter_pulse (Enter_pulse),
    .IsOp        (IsOp),
    .DataIn      (DataIn),
    .OpIn        (OpIn),
    .Top         (Top),
    .Count       (Count),
    .Status      (Status),
    .Busy        (Busy),
    .Error       (Error),
    .ErrCode     (ErrCode),
    .Carry       (Carry)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise Enter for one active edge; the edge after this call is not yet taken.
  task automatic enter(input logic isop, input logic [15:0] d, input logic [2:0] op);
    IsOp = isop; DataIn = d; OpIn = op; Enter_pulse = 1'b1;
    step();
    Enter_pulse = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    enter(1'b0, d, 3'd0);
    step();
  endtask

  task automatic do_op(input logic [2:0] op);
    enter(1'b1, 16'h0, op);
    step();
    step();
  endtask

  task automatic clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
  endtask

  initial begin
    // Reset values
    step(); step();
    chk("rst_top", Top, 0);
    chk("rst_count", Count, 0);
    chk("rst_status", Status, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_error", Error, 0);
    chk("rst_errcode", ErrCode, 0);
    chk("rst_carry", Carry, 0);
    Reset_n = 1'b1;
    step();

    // 1: 5 3 ADD with latency
    push(16'd5);
    chk("t1_push_top", Top, 5);
    push(16'd3);
    chk("t1_push2_top", Top, 3);
    chk("t1_push2_count", Count, 2);
    enter(1'b1, 16'h0, 3'd0);
    chk("t1_exec_status", Status, 2);
    chk("t1_exec_busy", Busy, 1);
    step();
    chk("t1_wb_status", Status, 3);
    chk("t1_wb_top_old", Top, 3);
    step();
    chk("t1_add_top", Top, 8);
    chk("t1_add_count", Count, 1);
    chk("t1_add_carry", Carry, 0);
    chk("t1_idle", Status, 0);
    clear();
    chk("t1_clear_count", Count, 0);
    chk("t1_clear_top", Top, 0);

    // 2: wraparound ADD and borrowing SUB
    push(16'hFFFF); push(16'h0001); do_op(3'd0);
    chk("t2_add_top", Top, 16'h0000);
    chk("t2_add_carry", Carry, 1);
    clear();
    push(16'd2); push(16'd5); do_op(3'd1);
    chk("t2_sub_top", Top, 16'hFFFD);
    chk("t2_sub_carry", Carry, 1);
    clear();
    push(16'h00F0); push(16'h0004); do_op(3'd5);
    chk("t2_shl_top", Top, 16'h0F00);
    chk("t2_shl_carry", Carry, 0);
    clear();
    push(16'h0F0F); push(16'h00FF); do_op(3'd4);
    chk("t2_xor_top", Top, 16'h0FF0);
    clear();

    // 3: overflow
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    chk("t3_full_count", Count, 4);
    enter(1'b0, 16'd5, 3'd0);
    chk("t3_ovf_error", Error, 1);
    chk("t3_ovf_code", ErrCode, 1);
    chk("t3_ovf_status", Status, 4);
    chk("t3_ovf_count", Count, 4);
    chk("t3_ovf_top", Top, 4);
    step();
    chk("t3_err_hold", Error, 1);
    enter(1'b0, 16'd9, 3'd0);
    chk("t3_leave_error", Error, 0);
    chk("t3_leave_code", ErrCode, 0);
    chk("t3_leave_status", Status, 0);
    chk("t3_leave_top", Top, 4);
    do_op(3'd0);
    chk("t3_intact_top", Top, 7);
    chk("t3_intact_count", Count, 3);
    clear();

    // 4: underflow and illegal opcode
    push(16'd7);
    enter(1'b1, 16'h0, 3'd2);
    chk("t4_unf_code", ErrCode, 2);
    chk("t4_unf_count", Count, 1);
    enter(1'b0, 16'h0, 3'd0);
    push(16'd9);
    enter(1'b1, 16'h0, 3'd7);
    chk("t4_opc_code", ErrCode, 3);
    chk("t4_opc_count", Count, 2);
    chk("t4_opc_top", Top, 9);
    enter(1'b0, 16'h0, 3'd0);
    clear();

    // 5: opcode 6
    push(16'd300); push(16'd300);
`ifdef RPN_MUL_EN
    do_op(3'd6);
    chk("t5_mul_top", Top, 16'h5F90);
    chk("t5_mul_carry", Carry, 1);
    chk("t5_mul_count", Count, 1);
`else
    enter(1'b1, 16'h0, 3'd6);
    chk("t5_mul_code", ErrCode, 3);
    chk("t5_mul_count", Count, 2);
    enter(1'b0, 16'h0, 3'd0);
`endif
    clear();

    // 6a: Enter ignored while Busy
    push(16'd1); push(16'd2);
    enter(1'b1, 16'h0, 3'd0);
    enter(1'b0, 16'h0055, 3'd0);
    step();
    chk("t6_busy_top", Top, 3);
    chk("t6_busy_count", Count, 1);
    step();
    chk("t6_busy_nopush", Count, 1);
    chk("t6_busy_idle", Status, 0);
    clear();

    // 6b: Clear during WB drops the writeback
    push(16'hFFFF); push(16'h0001);
    enter(1'b1, 16'h0, 3'd0);
    step();
    chk("t6_wb_status", Status, 3);
    clear();
    chk("t6_clr_count", Count, 0);
    chk("t6_clr_status", Status, 0);
    chk("t6_clr_carry", Carry, 0);
    chk("t6_clr_top", Top, 0);

    // 6c: Clear beats a simultaneous Enter
    Clear = 1'b1; IsOp = 1'b0; DataIn = 16'd11; Enter_pulse = 1'b1;
    step();
    Clear = 1'b0; Enter_pulse = 1'b0;
    step();
    chk("t6_clrent_count", Count, 0);
    chk("t6_clrent_status", Status, 0);

    // 6d: asynchronous reset mid-EXEC
    push(16'd7); push(16'd8);
    enter(1'b1, 16'h0, 3'd0);
    chk("t6_rst_pre_status", Status, 2);
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_rst_status", Status, 0);
    chk("t6_rst_count", Count, 0);
    chk("t6_rst_top", Top, 0);
    chk("t6_rst_busy", Busy, 0);
    step();
    Reset_n = 1'b1;
    step(); step();
    chk("t6_rst_lost_count", Count, 0);
    chk("t6_rst_lost_top", Top, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
